// File: rtl/adam_pause_pkg.sv
// Shared types and helpers for the adam_pause_seq pause sequencer.
package adam_pause_pkg;

    typedef enum logic [1:0] {
        RUNNING  = 2'd0,
        PAUSING  = 2'd1,
        PAUSED   = 2'd2,
        RESUMING = 2'd3
    } pause_state_t;

    // Counter width able to hold 0..timeout; a disabled timeout still gets one bit.
    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/adam_pause_timer.sv
// Per-step acknowledge timer: counts up from a clear, saturates at TIMEOUT.
module adam_pause_timer
    import adam_pause_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, clr};
            assign expired = 1'b0;
        end else begin : g_on
            localparam int TW = timer_width(TIMEOUT);
            logic [TW-1:0] count_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (clr) begin
                    count_reg <= '0;
                end else if (count_reg != TW'(TIMEOUT)) begin
                    count_reg <= count_reg + TW'(1);
                end
            end

            assign expired = (count_reg == TW'(TIMEOUT));
        end
    endgenerate

endmodule

// File: rtl/adam_pause_seq.sv
// Pause sequencer: fans one upstream pause handshake out to NO_CHANNELS
// downstream handshakes, pausing in ascending and resuming in descending order.
module adam_pause_seq
    import adam_pause_pkg::*;
#(
    parameter int NO_CHANNELS  = 4,
    parameter int TIMEOUT      = 1024,
    parameter bit RESET_PAUSED = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   up_req,
    output logic                   up_ack,
    output logic [NO_CHANNELS-1:0] ch_req,
    input  logic [NO_CHANNELS-1:0] ch_ack,
    input  logic [NO_CHANNELS-1:0] ch_en,
    input  logic                   err_clr,
    output logic [NO_CHANNELS-1:0] timeout_err,
    output logic                   busy
);

    localparam int            IW   = (NO_CHANNELS > 1) ? $clog2(NO_CHANNELS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NO_CHANNELS - 1);

    pause_state_t           state_reg;
    logic [IW-1:0]          idx_reg;
    logic [IW-1:0]          idx_inc;
    logic [IW-1:0]          idx_dec;
    logic [NO_CHANNELS-1:0] req_q;
    logic                   in_step;
    logic                   ack_met;
    logic                   expired;
    logic                   tmo_hit;
    logic                   step_done;

    assign in_step = (state_reg == PAUSING) || (state_reg == RESUMING);
    assign idx_inc = idx_reg + IW'(1);
    assign idx_dec = idx_reg - IW'(1);

    // A disabled channel completes its step immediately, whatever its ack says.
    assign ack_met   = !ch_en[idx_reg] ||
                       ((state_reg == PAUSING) ? ch_ack[idx_reg] : !ch_ack[idx_reg]);
    assign tmo_hit   = in_step && expired && !ack_met;
    assign step_done = in_step && (ack_met || expired);

    assign ch_req = req_q & ch_en;

    adam_pause_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!in_step || step_done),
        .expired (expired)
    );

    // The direction of travel is decided from up_req as each step completes,
    // so a reversal never abandons a step half-done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= RESET_PAUSED ? PAUSED : RUNNING;
            idx_reg     <= RESET_PAUSED ? LAST : '0;
            req_q       <= {NO_CHANNELS{RESET_PAUSED}};
            up_ack      <= RESET_PAUSED;
            busy        <= 1'b0;
            timeout_err <= '0;
        end else begin
            if (err_clr) begin
                timeout_err <= '0;
            end
            if (tmo_hit) begin
                timeout_err[idx_reg] <= 1'b1;
            end

            case (state_reg)
                RUNNING: begin
                    if (up_req) begin
                        state_reg <= PAUSING;
                        idx_reg   <= '0;
                        req_q[0]  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                PAUSING: begin
                    if (step_done) begin
                        if (!up_req) begin
                            state_reg      <= RESUMING;
                            req_q[idx_reg] <= 1'b0;
                        end else if (idx_reg == LAST) begin
                            state_reg <= PAUSED;
                            up_ack    <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            idx_reg        <= idx_inc;
                            req_q[idx_inc] <= 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (!up_req) begin
                        state_reg   <= RESUMING;
                        idx_reg     <= LAST;
                        req_q[LAST] <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                RESUMING: begin
                    if (step_done) begin
                        if (up_req) begin
                            state_reg      <= PAUSING;
                            req_q[idx_reg] <= 1'b1;
                        end else if (idx_reg == '0) begin
                            state_reg <= RUNNING;
                            up_ack    <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            idx_reg        <= idx_dec;
                            req_q[idx_dec] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/adam_pause_seq.md
Name: adam_pause_seq

Overview:
- Parametrised pause sequencer. Fans one upstream pause request/acknowledge handshake out to NO_CHANNELS downstream pause handshakes.
- Pauses channels in ascending index order and resumes them in descending index order.
- Adds per-channel enable masking, per-step acknowledge timeout with sticky error flags, a reset-paused mode, and mid-sequence direction reversal.
- Sits between a domain's pause input and its bus and peripheral pause ports, replacing tied-on pause masters.

Parameters:
- NO_CHANNELS, 4, number of downstream pause channels (1..32).
- TIMEOUT, 1024, cycles to wait for an acknowledge per step. 0 disables the timeout.
- RESET_PAUSED, 1, 1 = block leaves reset in PAUSED state; 0 = leaves reset in RUNNING state.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- up_req  in  1  upstream pause request
- up_ack  out  1  upstream pause acknowledge
- ch_req  out  NO_CHANNELS  downstream pause requests
- ch_ack  in  NO_CHANNELS  downstream pause acknowledges
- ch_en  in  NO_CHANNELS  channel enable, quasi-static
- err_clr  in  1  clears timeout_err
- timeout_err  out  NO_CHANNELS  sticky per-channel timeout flags
- busy  out  1  high in PAUSING or RESUMING

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Output gating: ch_req = req_q & ch_en. A disabled channel never sees a request, its ack is ignored, and its step costs exactly 1 cycle.
- Reset values:
  - state = PAUSED if RESET_PAUSED else RUNNING.
  - req_q = all ones if RESET_PAUSED else 0.
  - up_ack = RESET_PAUSED; idx = 0 if RESET_PAUSED... no: idx = NO_CHANNELS-1 if RESET_PAUSED else 0.
  - timeout_err = 0, busy = 0, timer = 0.
- FSM states: RUNNING, PAUSING, PAUSED, RESUMING. idx holds the current step index.
- RUNNING: up_req=1 sampled -> PAUSING, idx=0, req_q[0] set on the same edge.
- PAUSING at idx:
  - Step completes when ch_ack[idx]=1, or the channel is disabled, or the timer reaches TIMEOUT. On timeout, timeout_err[idx] is set.
  - On completion with idx<N-1: idx++, req_q[idx+1] set on the same edge, timer cleared.
  - On completion with idx=N-1: -> PAUSED, up_ack=1 registered on that edge.
- PAUSED: up_req=0 sampled -> RESUMING, idx=N-1, req_q[N-1] cleared.
- RESUMING at idx:
  - Step completes when ch_ack[idx]=0, or the channel is disabled, or timeout (sets timeout_err[idx]).
  - On completion with idx>0: idx--, req_q[idx-1] cleared.
  - On completion with idx=0: -> RUNNING, up_ack=0.
- up_ack changes only on PAUSED entry or exit: 1 on PAUSED entry, held in PAUSED, 0 on RUNNING entry.
- Latency: with acks that respond in the cycle req is seen, a full pause takes N+1 edges from up_req sampled to up_ack high. Resume is symmetric.
- Reversal during PAUSING (up_req=0 seen mid-sequence):
  - The current step completes first.
  - Then -> RESUMING at the same idx, and req_q[idx] is cleared.
  - Already-paused channels are then resumed in descending order. up_ack stays 0.
- Reversal during RESUMING (up_req=1 seen mid-sequence):
  - The current step completes (ack low).
  - Then -> PAUSING at the same idx, and req_q[idx] is set again.
- Timer: width $clog2(TIMEOUT+1). Cleared on every step transition. Saturates at TIMEOUT.
- Errors: timeout_err bits are sticky. err_clr clears all bits. If err_clr coincides with a new timeout, the set wins.
- ch_en changes take effect on ch_req combinationally. Changing ch_en during busy is legal but unspecified for ordering guarantees.
- Reset mid-sequence: all state returns to its reset value immediately, asynchronously.

Decomposition:
- Package adam_pause_pkg holds:
  - the state enum pause_state_t (RUNNING, PAUSING, PAUSED, RESUMING);
  - the function timer_width(TIMEOUT).
- Sub-module adam_pause_timer: per-step saturating counter with clear and expired outputs. A TIMEOUT=0 instance ties expired to 0.
- Top-level holds the FSM, idx, req_q and the error register.

Test Plan:
- Pause, instant acks: RESET_PAUSED=0, N=4, all enabled, ch_ack mirrors ch_req. up_req rises -> ch_req goes 0001, 0011, 0111, 1111 on consecutive edges; up_ack=1 on the 5th edge. Release up_req -> ch_req 0111, 0011, 0001, 0000; up_ack=0 on the 5th edge.
- Timeout: TIMEOUT=8, ch_ack[2] stuck 0 -> pause step 2 lasts 9 cycles, timeout_err=0100, sequence completes with up_ack=1. Pulse err_clr -> timeout_err=0000.
- Disabled channel: ch_en=1011 -> ch_req[2] stays 0 throughout, step 2 costs 1 cycle, total pause latency is still 5 edges.
- Reversal while pausing: up_req drops while waiting at idx=2 (ack delayed 3 cycles) -> after ack2, ch_req=0011, then 0001, 0000. up_ack is never asserted.
- Reset paused: RESET_PAUSED=1 -> after rst_n deassert, up_ack=1 and ch_req=ch_en. up_req=0 -> resume order 3, 2, 1, 0.
- Reset mid-sequence: assert rst_n low during PAUSING idx=1 -> ch_req, up_ack and busy return to reset values in the same cycle, asynchronously.
